sync_ptr_mc: RTL and testbench

//  Multi-channel, depth-configurable synchronizer for Gray-coded FIFO pointers entering the dest_clk domain.
//  Per channel: STAGES-flop sync chain, registered Gray->binary conversion, per-cycle advance (delta), change pulse.

---
 rtl/sync_ptr_mc_pkg.sv | 24 ++
 rtl/sync_ptr_mc_if.sv | 24 ++
 rtl/sync_ptr_mc_chan.sv | 81 ++++++++
 rtl/sync_ptr_mc.sv | 57 +++++
 tb/tb_sync_ptr_mc.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/sync_ptr_mc_pkg.sv
// Shared types and Gray-code helpers for the multi-channel pointer synchronizer.
// Pointers up to PTR_MAX_W bits are handled by zero-extending into ptr_max_t.
package sync_ptr_pkg;

    localparam int unsigned MIN_STAGES = 2;
    localparam int unsigned PTR_MAX_W  = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // The XOR prefix runs from the MSB down; zero upper bits leave the low bits exact.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_ptr_mc_if.sv
// Pointer bundle between source-side FIFO logic and the dest_clk synchronizer.
interface sync_ptr_mc_if #(
    parameter int unsigned ASIZE = 4,
    parameter int unsigned NCH   = 1
);
    logic [NCH-1:0][ASIZE:0] src_ptr_gray;
    logic [NCH-1:0][ASIZE:0] dest_ptr_gray;
    logic [NCH-1:0][ASIZE:0] dest_ptr_bin;
    logic [NCH-1:0][ASIZE:0] dest_delta;
    logic [NCH-1:0]          dest_chg;
    logic [NCH-1:0]          dest_err;
    logic                    dest_vld;
    logic                    err_clr;

    modport master (
        output src_ptr_gray, err_clr,
        input  dest_ptr_gray, dest_ptr_bin, dest_delta, dest_chg, dest_vld, dest_err
    );

    modport slave (
        input  src_ptr_gray, err_clr,
        output dest_ptr_gray, dest_ptr_bin, dest_delta, dest_chg, dest_vld, dest_err
    );
endinterface

// File: rtl/sync_ptr_mc_chan.sv
// One pointer channel: sync chain, registered Gray->binary, delta/change pulse.
// Step checker present only when SYNC_PTR_STEP_CHECK_EN is defined.
module sync_ptr_chan
    import sync_ptr_pkg::*;
#(
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned MAX_STEP = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           vld_i,
    input  logic [ASIZE:0] src_gray_i,
    input  logic           err_clr_i,
    output logic [ASIZE:0] gray_o,
    output logic [ASIZE:0] bin_o,
    output logic [ASIZE:0] delta_o,
    output logic           chg_o,
    output logic           err_o
);
    localparam int unsigned W = ASIZE + 1;
    typedef logic [W-1:0] ptr_t;

    (* ASYNC_REG = "TRUE" *) ptr_t [STAGES-1:0] sync_q;

    ptr_t bin_q, bin_d;
    ptr_t delta_q, delta_d;
    ptr_t delta_n;
    logic chg_q, chg_d;

    // Delta is computed against the previous registered binary pointer, modulo 2**W.
    always_comb begin
        bin_d   = ptr_t'(gray2bin(ptr_max_t'(sync_q[STAGES-1])));
        delta_n = bin_d - bin_q;
        delta_d = vld_i ? delta_n : '0;
        chg_d   = vld_i && (delta_n != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], src_gray_i};
            bin_q   <= bin_d;
            delta_q <= delta_d;
            chg_q   <= chg_d;
        end
    end

    assign gray_o  = sync_q[STAGES-1];
    assign bin_o   = bin_q;
    assign delta_o = delta_q;
    assign chg_o   = chg_q;

`ifdef SYNC_PTR_STEP_CHECK_EN
    localparam ptr_t MAX_STEP_P = ptr_t'(MAX_STEP);
    logic err_q, err_d;

    // Setting has priority over a same-cycle clear so no violation is lost.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) err_d = 1'b0;
        if (vld_i && (delta_n > MAX_STEP_P)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{err_clr_i, 32'(MAX_STEP)};
    assign err_o      = 1'b0;
`endif

endmodule

// File: rtl/sync_ptr_mc.sv
// Multi-channel Gray pointer synchronizer into dest_clk; shared prime counter drives dest_vld.
// Optional per-channel step checker: SYNC_PTR_STEP_CHECK_EN.
module sync_ptr_mc
    import sync_ptr_pkg::*;
#(
    parameter int unsigned ASIZE    = 4,
    parameter int unsigned NCH      = 1,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned MAX_STEP = 1
) (
    input logic          dest_clk,
    input logic          dest_rst,
    sync_ptr_mc_if.slave bus
);
    localparam int unsigned NSTG      = (STAGES < MIN_STAGES) ? MIN_STAGES : STAGES;
    localparam int unsigned PRIME_MAX = NSTG + 1;
    localparam int unsigned CW        = $clog2(PRIME_MAX + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t PRIME_DONE = cnt_t'(PRIME_MAX);

    cnt_t prime_q, prime_d;
    logic vld;

    // Saturates once dest_ptr_bin holds a genuine post-reset sample.
    always_comb begin
        prime_d = prime_q;
        if (prime_q != PRIME_DONE) prime_d = prime_q + cnt_t'(1);
    end

    always_ff @(posedge dest_clk) begin
        if (dest_rst) prime_q <= '0;
        else          prime_q <= prime_d;
    end

    assign vld          = (prime_q == PRIME_DONE);
    assign bus.dest_vld = vld;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        sync_ptr_chan #(
            .ASIZE    (ASIZE),
            .STAGES   (NSTG),
            .MAX_STEP (MAX_STEP)
        ) u_chan (
            .clk_i      (dest_clk),
            .rst_i      (dest_rst),
            .vld_i      (vld),
            .src_gray_i (bus.src_ptr_gray[c]),
            .err_clr_i  (bus.err_clr),
            .gray_o     (bus.dest_ptr_gray[c]),
            .bin_o      (bus.dest_ptr_bin[c]),
            .delta_o    (bus.dest_delta[c]),
            .chg_o      (bus.dest_chg[c]),
            .err_o      (bus.dest_err[c])
        );
    end

endmodule

// File: tb/tb_sync_ptr_mc.sv
// Bench for sync_ptr_mc: directed phases then randomized advances with a mid-stream reset,
// checked every cycle against a history-based reference model.
module tb_sync_ptr_mc;
    import sync_ptr_pkg::*;

    localparam int unsigned ASIZE    = 4;
    localparam int unsigned NCH      = 4;
    localparam int unsigned STAGES   = 3;
    localparam int unsigned MAX_STEP = 1;
    localparam int unsigned W        = ASIZE + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    sync_ptr_mc_if #(.ASIZE(ASIZE), .NCH(NCH)) bus ();

    sync_ptr_mc #(
        .ASIZE    (ASIZE),
        .NCH      (NCH),
        .STAGES   (STAGES),
        .MAX_STEP (MAX_STEP)
    ) u_dut (
        .dest_clk (clk),
        .dest_rst (rst),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] src_bin [NCH];
    logic [W-1:0] hist    [NCH][$];
    int           k = 0;
    logic [NCH-1:0] err_m = '0;

    function automatic logic [W-1:0] g(input logic [W-1:0] b);
        return W'(bin2gray(ptr_max_t'(b)));
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_drv
        assign bus.src_ptr_gray[c] = g(src_bin[c]);
    end
    assign bus.err_clr = clr;

    task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s ch%0d observed=%0h expected=%0h t=%0t", tag, c, obs, exp, $time);
        end
    endtask

    // Model: after k clean edges, the chain holds the last k samples (newest at age 0).
    task automatic tick();
        logic [W-1:0] d;
        logic [W-1:0] gray_e, bin_e, delta_e;
        logic [NCH-1:0] err_e;
        @(posedge clk);
        if (rst) begin
            k = 0;
            err_m = '0;
            for (int c = 0; c < NCH; c++) hist[c].delete();
        end else begin
            if (k < 1000) k++;
            for (int c = 0; c < NCH; c++) begin
                hist[c].push_front(src_bin[c]);
                if (hist[c].size() > STAGES + 2) void'(hist[c].pop_back());
                if (clr) err_m[c] = 1'b0;
                if (k >= STAGES + 2) begin
                    d = hist[c][STAGES] - hist[c][STAGES+1];
                    if (int'(d) > int'(MAX_STEP)) err_m[c] = 1'b1;
                end
            end
        end
`ifdef SYNC_PTR_STEP_CHECK_EN
        err_e = err_m;
`else
        err_e = '0;
`endif
        #1;
        check("vld", 0, 32'(bus.dest_vld), 32'(k >= STAGES + 1));
        for (int c = 0; c < NCH; c++) begin
            gray_e  = (k >= STAGES)     ? g(hist[c][STAGES-1]) : '0;
            bin_e   = (k >= STAGES + 1) ? hist[c][STAGES]      : '0;
            delta_e = (k >= STAGES + 2) ? W'(hist[c][STAGES] - hist[c][STAGES+1]) : '0;
            check("gray",  c, 32'(bus.dest_ptr_gray[c]), 32'(gray_e));
            check("bin",   c, 32'(bus.dest_ptr_bin[c]),  32'(bin_e));
            check("delta", c, 32'(bus.dest_delta[c]),    32'(delta_e));
            check("chg",   c, 32'(bus.dest_chg[c]),      32'(delta_e != '0));
            check("err",   c, 32'(bus.dest_err[c]),      32'(err_e[c]));
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) src_bin[c] = W'(7);

        // Reset with a stable pointer, then idle through priming.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (7) tick();

        // Single step on channel 0.
        src_bin[0] = W'(8);
        repeat (6) tick();

        // Wrap 31 -> 0.
        src_bin[0] = W'(31);
        repeat (6) tick();
        src_bin[0] = W'(0);
        repeat (6) tick();

        // Fast source: 3 -> 6 on channel 1, error holds, then clear pulse.
        src_bin[1] = W'(3);
        repeat (6) tick();
        src_bin[1] = W'(6);
        repeat (8) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (4) tick();

        // Only channel 2 moves.
        src_bin[2] = src_bin[2] + W'(1);
        repeat (7) tick();

        // Randomized advances, sporadic clears, reset in the middle.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NCH; c++) begin
                case ($urandom_range(0, 9))
                    6, 7, 8: src_bin[c] = src_bin[c] + W'(1);
                    9:       src_bin[c] = src_bin[c] + W'($urandom_range(2, 16));
                    default: ;
                endcase
            end
            clr = ($urandom_range(0, 15) == 0);
            rst = (i >= 150 && i < 152);
            tick();
        end

        clr = 1'b0;
        rst = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
